// File: rtl/riscv_pkg.sv
// riscv_pkg: types and constants shared across the core pipeline.
// Fetch FSM states, IF/ID bundle, NOP word and base opcodes.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
  localparam logic [6:0] OPC_STORE    = 7'b010_0011;
  localparam logic [6:0] OPC_OP       = 7'b011_0011;
  localparam logic [6:0] OPC_LUI      = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
  localparam logic [6:0] OPC_JALR     = 7'b110_0111;
  localparam logic [6:0] OPC_JAL      = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

  typedef enum logic [2:0] {
    FS_BOOT,
    FS_REQ,
    FS_WAIT,
    FS_DROP,
    FS_HOLD
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } if_id_t;

  function automatic logic [XLEN-1:0] pc_plus4(
    input logic [XLEN-1:0] pc
  );
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {valid, instr, pc} holding buffer.
// Ports: i_clk, i_rst_n, i_load/i_drain/i_clear, i_instr/i_pc in, o_valid/o_instr/o_pc out.
module fetch_skid_buf
  import riscv_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_drain,
  input  logic            i_clear,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc
);

  if_id_t r_entry;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_entry <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0};
    end else if (i_clear) begin
      r_entry.valid <= 1'b0;
    end else if (i_load) begin
      r_entry <= '{valid: 1'b1, instr: i_instr, pc: i_pc};
    end else if (i_drain) begin
      r_entry.valid <= 1'b0;
    end
  end

  assign o_valid = r_entry.valid;
  assign o_instr = r_entry.instr;
  assign o_pc    = r_entry.pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, imem req/gnt/rvalid fetch FSM, IF/ID register.
// Ports: clk_i, rst_ni, imem_* (fetch bus), redirect_*, stall_i, if_id_* (to decode).
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_i,
  output logic            if_id_valid_o,
  output logic [31:0]     if_id_instr_o,
  output logic [XLEN-1:0] if_id_pc_o,
  output logic [XLEN-1:0] if_id_pc4_o
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  if_id_t          r_if_id;

  logic            w_skid_valid;
  logic [31:0]     w_skid_instr;
  logic [XLEN-1:0] w_skid_pc;

  logic            w_hold;
  logic            w_deliver;
  logic            w_skid_load;
  logic            w_skid_drain;
  logic [XLEN-1:0] w_target;
  logic            w_unused_lo;

  // EX owns alignment; low target bits are dropped.
  assign w_target    = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign w_unused_lo = ^redirect_pc_i[1:0];

  // A stall only freezes IF/ID when it holds something.
  assign w_hold       = stall_i & r_if_id.valid;
  assign w_deliver    = (r_state == FS_WAIT) &
                        imem_rvalid_i & ~redirect_i;
  assign w_skid_load  = w_deliver & w_hold;
  assign w_skid_drain = w_skid_valid & ~w_hold & ~redirect_i;

  fetch_skid_buf u_skid (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_load  (w_skid_load),
    .i_drain (w_skid_drain),
    .i_clear (redirect_i),
    .i_instr (imem_rdata_i),
    .i_pc    (r_pc),
    .o_valid (w_skid_valid),
    .o_instr (w_skid_instr),
    .o_pc    (w_skid_pc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= FS_BOOT;
      r_pc    <= RESET_PC;
    end else begin
      if (redirect_i) begin
        r_pc <= w_target;
      end else if (w_deliver) begin
        r_pc <= pc_plus4(r_pc);
      end
      unique case (r_state)
        FS_BOOT: r_state <= FS_REQ;
        FS_REQ: begin
          // a grant alongside a redirect leaves a stale response in flight
          if (imem_gnt_i) begin
            r_state <= redirect_i ? FS_DROP : FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (redirect_i) begin
            r_state <= imem_rvalid_i ? FS_REQ : FS_DROP;
          end else if (imem_rvalid_i) begin
            r_state <= w_hold ? FS_HOLD : FS_REQ;
          end
        end
        FS_DROP: begin
          if (imem_rvalid_i) begin
            r_state <= FS_REQ;
          end
        end
        FS_HOLD: begin
          // no new request until the skid entry has moved on
          if (redirect_i || w_skid_drain) begin
            r_state <= FS_REQ;
          end
        end
        default: r_state <= FS_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_if_id <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0};
    end else if (redirect_i) begin
      r_if_id.valid <= 1'b0;
      r_if_id.instr <= NOP_INSTR;
    end else if (w_hold) begin
      r_if_id <= r_if_id;
    end else if (w_skid_valid) begin
      r_if_id <= '{valid: 1'b1, instr: w_skid_instr, pc: w_skid_pc};
    end else if (w_deliver) begin
      r_if_id <= '{valid: 1'b1, instr: imem_rdata_i, pc: r_pc};
    end else begin
      r_if_id.valid <= 1'b0;
      r_if_id.instr <= NOP_INSTR;
    end
  end

  assign imem_req_o    = (r_state == FS_REQ);
  assign imem_addr_o   = r_pc;
  assign if_id_valid_o = r_if_id.valid;
  assign if_id_instr_o = r_if_id.instr;
  assign if_id_pc_o    = r_if_id.pc;
  assign if_id_pc4_o   = pc_plus4(r_if_id.pc);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: vector table, directed corner sequences and
// random traffic checked against a program-order instruction stream model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_fetch_unit u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .if_id_valid_o (if_id_valid_o),
    .if_id_instr_o (if_id_instr_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_pc4_o   (if_id_pc4_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // memory model state
  bit          busy;
  int          lat;
  logic [31:0] paddr;
  int          deny;
  int          fixed_lat;
  bit          rand_mode;
  bit          nop_mode;

  // stream model state
  bit          model_on;
  logic [31:0] exp_pc;
  int          n_consumed;
  bit          prev_pend;
  logic [31:0] prev_addr;

  typedef struct {
    bit          stall;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dat(input logic [31:0] a);
    if (nop_mode) return NOP;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One cycle: drive memory for the coming edge, check, advance to negedge.
  task automatic tick();
    if (prev_pend) begin
      chk("addr_hold", imem_addr_o, prev_addr);
      chk("req_hold", 32'(imem_req_o), 32'd1);
    end
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (busy) begin
      if (lat == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = dat(paddr);
        busy          = 1'b0;
      end else begin
        lat--;
      end
    end
    if (imem_rvalid_i)
      chk("skid_empty_on_rsp", 32'(u_dut.u_skid.o_valid), 32'd0);
    imem_gnt_i = 1'b0;
    if (imem_req_o) begin
      chk("addr_align", 32'(imem_addr_o[1:0]), 32'd0);
      chk("one_outstanding", 32'(busy | imem_rvalid_i), 32'd0);
      if (deny > 0) begin
        deny--;
      end else if (!rand_mode || $urandom_range(1, 0) == 1) begin
        imem_gnt_i = 1'b1;
        busy       = 1'b1;
        paddr      = imem_addr_o;
        lat        = rand_mode ? int'($urandom_range(2, 0)) : fixed_lat;
      end
    end
    prev_pend = imem_req_o && !imem_gnt_i && !redirect_i;
    prev_addr = imem_addr_o;
    if (model_on) begin
      if (if_id_valid_o && !stall_i && !redirect_i) begin
        chk("stream_pc", if_id_pc_o, exp_pc);
        chk("stream_instr", if_id_instr_o, dat(exp_pc));
        chk("stream_pc4", if_id_pc4_o, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        n_consumed++;
      end
      if (redirect_i) exp_pc = {redirect_pc_i[31:2], 2'b00};
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_ni        = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    busy          = 1'b0;
    lat           = 0;
    deny          = 0;
    prev_pend     = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(imem_req_o), 32'd0);
    chk({tag, "_addr"}, imem_addr_o, 32'h0);
    chk({tag, "_valid"}, 32'(if_id_valid_o), 32'd0);
    chk({tag, "_instr"}, if_id_instr_o, NOP);
    chk({tag, "_pc"}, if_id_pc_o, 32'h0);
    chk({tag, "_pc4"}, if_id_pc4_o, 32'h4);
  endtask

  initial begin
    int cnt4;
    tbl[0]  = '{0, 0, 32'h00, 0, 32'h0};
    tbl[1]  = '{0, 1, 32'h00, 0, 32'h0};
    tbl[2]  = '{0, 0, 32'h00, 0, 32'h0};
    tbl[3]  = '{0, 1, 32'h04, 1, 32'h0};
    tbl[4]  = '{0, 0, 32'h04, 0, 32'h0};
    tbl[5]  = '{1, 1, 32'h08, 1, 32'h4};
    tbl[6]  = '{1, 0, 32'h08, 1, 32'h4};
    tbl[7]  = '{1, 0, 32'h0C, 1, 32'h4};
    tbl[8]  = '{1, 0, 32'h0C, 1, 32'h4};
    tbl[9]  = '{0, 0, 32'h0C, 1, 32'h4};
    tbl[10] = '{0, 1, 32'h0C, 1, 32'h8};
    tbl[11] = '{0, 0, 32'h0C, 0, 32'h0};
    tbl[12] = '{0, 1, 32'h10, 1, 32'hC};

    rand_mode = 1'b0;
    nop_mode  = 1'b1;
    fixed_lat = 0;
    model_on  = 1'b0;
    exp_pc    = '0;
    n_consumed = 0;
    rst_ni        = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    @(negedge clk);
    chk_reset_vals("reset");

    // zero-wait stream with a 4-cycle stall over the 0x8 response
    do_reset();
    for (int i = 0; i < 13; i++) begin
      stall_i = tbl[i].stall;
      chk($sformatf("tbl%0d_req", i), 32'(imem_req_o), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i), imem_addr_o, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 32'(if_id_valid_o),
          32'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_pc", i), if_id_pc_o, tbl[i].pc);
        chk($sformatf("tbl%0d_instr", i), if_id_instr_o, NOP);
        chk($sformatf("tbl%0d_pc4", i), if_id_pc4_o, tbl[i].pc + 32'd4);
      end
      tick();
    end
    stall_i = 1'b0;

    // grant withheld for 3 cycles on the 0x4 request
    do_reset();
    nop_mode = 1'b0;
    repeat (3) tick();
    deny = 3;
    for (int k = 0; k < 3; k++) begin
      chk("gdly_req", 32'(imem_req_o), 32'd1);
      chk("gdly_addr", imem_addr_o, 32'h4);
      tick();
    end
    chk("gdly_addr_gnt", imem_addr_o, 32'h4);
    cnt4 = 0;
    for (int k = 0; k < 6; k++) begin
      if (if_id_valid_o && if_id_pc_o == 32'h4) cnt4++;
      tick();
    end
    chk("gdly_single", 32'(cnt4), 32'd1);

    // redirect while WAIT, stale response two cycles later
    do_reset();
    fixed_lat = 1;
    repeat (2) tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    chk("rdw_req_drop", 32'(imem_req_o), 32'd0);
    chk("rdw_valid_drop", 32'(if_id_valid_o), 32'd0);
    tick();
    chk("rdw_req", 32'(imem_req_o), 32'd1);
    chk("rdw_addr", imem_addr_o, 32'h100);
    chk("rdw_valid", 32'(if_id_valid_o), 32'd0);
    fixed_lat = 0;
    repeat (2) tick();
    chk("rdw_new_valid", 32'(if_id_valid_o), 32'd1);
    chk("rdw_new_pc", if_id_pc_o, 32'h100);
    chk("rdw_new_instr", if_id_instr_o, dat(32'h100));

    // redirect with grant, then redirect with stall
    do_reset();
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h103;
    tick();
    redirect_i = 1'b0;
    chk("rdg_drop_req", 32'(imem_req_o), 32'd0);
    tick();
    chk("rdg_req", 32'(imem_req_o), 32'd1);
    chk("rdg_addr", imem_addr_o, 32'h100);
    chk("rdg_valid", 32'(if_id_valid_o), 32'd0);
    repeat (2) tick();
    chk("rdg_pc", if_id_pc_o, 32'h100);
    chk("rdg_instr", if_id_instr_o, dat(32'h100));
    stall_i       = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    tick();
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    chk("rds_valid", 32'(if_id_valid_o), 32'd0);
    chk("rds_instr", if_id_instr_o, NOP);
    tick();
    chk("rds_req", 32'(imem_req_o), 32'd1);
    chk("rds_addr", imem_addr_o, 32'h200);

    // pc wrap, then asynchronous reset mid-WAIT
    do_reset();
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    tick();
    chk("wrap_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    repeat (2) tick();
    chk("wrap_req", 32'(imem_req_o), 32'd1);
    chk("wrap_addr", imem_addr_o, 32'h0);
    chk("wrap_pc", if_id_pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_id_pc4_o, 32'h0);
    tick();
    #2 rst_ni = 1'b0;
    #1 chk_reset_vals("async_rst");
    do_reset();
    tick();
    chk("post_rst_req", 32'(imem_req_o), 32'd1);
    chk("post_rst_addr", imem_addr_o, 32'h0);

    // random traffic against the program-order stream
    do_reset();
    rand_mode  = 1'b1;
    model_on   = 1'b1;
    exp_pc     = '0;
    n_consumed = 0;
    for (int i = 0; i < 4000; i++) begin
      stall_i    = ($urandom_range(3, 0) == 0);
      redirect_i = ($urandom_range(24, 0) == 0);
      if ($urandom_range(3, 0) == 0)
        redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
      else
        redirect_pc_i = $urandom & 32'h0000_FFFF;
      tick();
    end
    model_on   = 1'b0;
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    chk("rand_progress", 32'(n_consumed >= 200), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the RISC-V core: owns the PC, issues word fetches to instruction memory over a request/grant/response handshake, and drives the IF/ID pipeline register whose instruction word feeds the main decoder's opcode input. Handles taken-branch/jump redirects from EX, decode stalls from the hazard unit, and a one-entry skid buffer so responses arriving during a stall are never lost. At most one memory request is outstanding.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- XLEN, 32, address/data width
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  XLEN  fetch address, bits [1:0] always 0
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response data valid (≥1 cycle after grant)
- imem_rdata_i  in  32  instruction word
- redirect_i  in  1  taken branch/jump from EX; flush and refetch
- redirect_pc_i  in  XLEN  redirect target; bits [1:0] ignored
- stall_i  in  1  hold IF/ID contents
- if_id_valid_o  out  1  IF/ID holds a valid instruction
- if_id_instr_o  out  32  instruction (opcode = [6:0] to decoder)
- if_id_pc_o  out  XLEN  address of if_id_instr_o
- if_id_pc4_o  out  XLEN  if_id_pc_o + 4 (JAL/JALR link value)

## Operation
- FSM states: BOOT, REQ, WAIT, DROP, HOLD. Reset state BOOT.
- imem_req_o = (state == REQ); imem_addr_o = pc register.
- BOOT: unconditionally → REQ.
- REQ: gnt & !redirect → WAIT. redirect & !gnt → pc ← target, stay REQ. redirect & gnt → pc ← target, → DROP (granted request is stale).
- WAIT: rvalid & !redirect → deliver word with pc, pc ← pc+4; → REQ if word went to IF/ID, → HOLD if it went to skid. redirect & !rvalid → pc ← target, → DROP. redirect & rvalid → discard word, pc ← target, → REQ.
- DROP: rvalid → discard, → REQ. redirect → pc ← target, stay DROP.
- HOLD: skid drains (moved into IF/ID) → REQ. redirect → clear skid, pc ← target, → REQ.
- Delivery: word loads IF/ID if (!if_id_valid | !stall_i); otherwise loads skid. Invariant: skid is empty whenever a response arrives (no request issued while skid full); bench asserts this.
- IF/ID update priority: redirect (valid ← 0, skid cleared) > stall_i (hold) > skid valid (IF/ID ← skid) > delivered word > valid ← 0.
- pc+4 wraps modulo 2^XLEN; no overflow flag.
- Misaligned targets are EX's responsibility; fetch silently word-aligns.

## Timing
- Reset values: imem_req_o 0, imem_addr_o RESET_PC, if_id_valid_o 0, if_id_instr_o 32'h0000_0013 (NOP), if_id_pc_o 0, if_id_pc4_o 4; pc = RESET_PC, skid empty.
- Flushed IF/ID also loads NOP into if_id_instr_o, so the decoder never sees X.
- First request: cycle 1 after reset release (BOOT costs one cycle).
- Zero-wait memory (gnt with req, rvalid next cycle): instruction visible in IF/ID the cycle after rvalid; peak throughput one instruction per 2 cycles.
- Redirect in cycle N: IF/ID invalid in N+1; new target on imem_addr_o in N+1 (REQ/HOLD) or after stale rvalid (DROP).
- Reset asserted mid-transaction: all state cleared asynchronously; an in-flight response after reset release is ignored because state is BOOT/REQ, not WAIT (memory must not return responses for pre-reset requests after release; documented system constraint).
- imem_addr_o stable while imem_req_o high and !imem_gnt_i, except on redirect.

## Structure
- riscv_pkg: XLEN, NOP_INSTR = 32'h0000_0013, fetch state enum, RISC-V opcode constants shared with main_decoder.
- Sub-module fetch_skid_buf: one-entry {valid, instr, pc} buffer with load/drain/clear; FSM and IF/ID register stay in instr_fetch_unit.

## Test plan
- Reset release, zero-wait memory returning 0x00000013 forever -> addresses 0x0,0x4,0x8 requested on cycles 1,3,5; if_id_pc_o 0x0 valid cycle 3.
- gnt delayed 3 cycles -> imem_addr_o held at 0x4 throughout; single response delivered once.
- stall_i high 4 cycles while word at 0x8 returns -> word held in skid, imem_req_o low (HOLD), IF/ID shows 0x8 the cycle after stall_i drops, then fetch resumes at 0xC.
- redirect_i to 0x100 while WAIT with rvalid 2 cycles later -> stale word discarded, if_id_valid_o 0, next request 0x100.
- redirect_i with target 0x103 same cycle as gnt -> DROP, then request at 0x100; redirect and stall_i together -> IF/ID flushed to NOP.
- PC at 0xFFFF_FFFC -> next request 0x0000_0000; rst_ni pulsed low mid-WAIT -> all outputs at reset values asynchronously.
